// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues I-cache reads and buffers up to two
// fetched {inst, pc+4} pairs ahead of the IF/ID latch, with redirect and halt handling.
module fetch_unit #(
  parameter logic [31:0] PC0 = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] imemaddr,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  input  logic        halt,
  output logic [31:0] inst_out,
  output logic [31:0] pcp4_out,
  output logic        inst_valid,
  output logic        flush_out
);

  typedef enum logic [1:0] {FETCH, DISCARD, HALT} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] saved_pc;
  logic [31:0] pc_plus4;
  logic [31:0] fifo_inst [2];
  logic [31:0] fifo_pcp4 [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic        ihit_eff;
  logic        push;
  logic        pop;
  logic        clear;

  assign pc_plus4 = pc + 32'd4;
  // A completion only means something while a request is actually outstanding.
  assign ihit_eff = ihit && iREN;
  assign push     = (state == FETCH) && ihit_eff && !redirect && !halt;
  assign pop      = inst_valid && !stall;
  assign clear    = halt || (redirect && (state != HALT));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH: begin
        if (halt) begin
          state_next = HALT;
        end else if (redirect && iREN && !ihit) begin
          state_next = DISCARD;
        end
      end
      DISCARD: begin
        if (halt) begin
          state_next = HALT;
        end else if (ihit_eff) begin
          state_next = FETCH;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    iREN = 1'b0;
    if (nRST) begin
      case (state)
        FETCH:   iREN = (count < 2'd2);
        DISCARD: iREN = 1'b1;
        default: iREN = 1'b0;
      endcase
    end
    imemaddr   = pc;
    flush_out  = redirect || halt;
    inst_valid = (count != 2'd0);
    inst_out   = inst_valid ? fifo_inst[rd_ptr] : 32'd0;
    pcp4_out   = inst_valid ? fifo_pcp4[rd_ptr] : 32'd0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc       <= PC0;
      saved_pc <= 32'd0;
    end else if (!halt) begin
      case (state)
        FETCH: begin
          if (redirect) begin
            // An in-flight read must complete before the new target can be issued.
            if (iREN && !ihit) begin
              saved_pc <= redirect_pc;
            end else begin
              pc <= redirect_pc;
            end
          end else if (ihit_eff) begin
            pc <= pc_plus4;
          end
        end
        DISCARD: begin
          if (redirect) begin
            saved_pc <= redirect_pc;
          end
          if (ihit_eff) begin
            pc <= redirect ? redirect_pc : saved_pc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else if (clear) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_inst[wr_ptr] <= imemload;
      fifo_pcp4[wr_ptr] <= pc_plus4;
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction Fetch stage of the pipelined MIPS core; sits directly upstream of the IF/ID latch. Owns the PC, issues instruction reads to the I-cache, and buffers returned instructions in a 2-entry queue so a decode stall never loses a fetched word. Handles branch/jump redirects, including ones that arrive while a cache read is outstanding, and stops fetching on halt.

## Interface
- PC0, 32'h00000000, PC value loaded on reset
- CLK  in  1  clock, all state updates on rising edge
- nRST  in  1  asynchronous, active-low reset
- ihit  in  1  I-cache: current request complete, imemload valid this cycle
- imemload  in  32  I-cache read data
- iREN  out  1  I-cache read enable
- imemaddr  out  32  I-cache read address
- redirect  in  1  branch/jump resolved taken; one-cycle pulse
- redirect_pc  in  32  target PC for redirect
- stall  in  1  IF/ID latch cannot accept an instruction this cycle
- halt  in  1  halt detected downstream; permanent until reset
- inst_out  out  32  head instruction, to IF/ID imemload_in
- pcp4_out  out  32  head PC+4, to IF/ID pcp4_in
- inst_valid  out  1  inst_out/pcp4_out valid
- flush_out  out  1  to IF/ID flush

## Operation
- State: pc (32), FSM state, saved_pc (32), 2-entry FIFO of {inst, pcp4}, count (0..2).
- FSM states: FETCH, DISCARD, HALT.
- iREN = nRST && ((FETCH && count<2) || DISCARD). imemaddr = pc. Once iREN rises, iREN and imemaddr stay stable until ihit (count cannot grow without ihit; redirect moves to DISCARD keeping the address).
- FETCH, ihit, no redirect/halt: push {imemload, pc+4}; pc <= pc+4 (modulo 2^32 wrap).
- Pop when inst_valid && !stall. Push and pop in same cycle: count unchanged. ihit never occurs with count==2 (iREN low).
- Redirect in FETCH, no outstanding request or ihit same cycle: FIFO cleared, that cycle's imemload dropped, pc <= redirect_pc, stay FETCH.
- Redirect in FETCH with iREN high and no ihit: FIFO cleared, saved_pc <= redirect_pc, go DISCARD.
- DISCARD: keep pc/imemaddr; on ihit drop data, pc <= saved_pc, go FETCH. Further redirect in DISCARD overwrites saved_pc (ihit same cycle: pc <= new redirect_pc, go FETCH).
- halt in any state: FIFO cleared, go HALT, any ihit that cycle dropped. Halt beats redirect when simultaneous.
- HALT: iREN=0, inst_valid=0, redirect ignored; exit only via nRST.
- flush_out = redirect || halt (combinational, same cycle) so IF/ID clears its content at that edge.
- inst_out/pcp4_out = FIFO head when count>0, else 0. inst_valid = (count>0).

## Timing
- Reset (nRST low, async): pc=PC0, state FETCH, count=0, saved_pc=0; iREN=0, inst_valid=0, inst_out=0, pcp4_out=0, imemaddr=PC0; flush_out follows redirect||halt.
- First request: iREN=1 in first cycle after nRST deasserts.
- Latency: ihit in cycle N -> inst_valid=1 with that word in cycle N+1. Zero-wait cache sustains one instruction/cycle.
- Redirect in cycle N: no instruction from the old path is ever valid from cycle N+1 on; first target instruction valid one cycle after its ihit.
- Reset mid-request: request abandoned, iREN low immediately; no state survives.

## Test plan
- Reset, PC0=0, ihit tied 1, imemload=addr|0xA000_0000: imemaddr 0,4,8 on consecutive cycles; inst_valid from cycle 2, inst_out 0xA0000000,0xA0000004…, pcp4_out 4,8,….
- Zero-wait cache, stall held 3 cycles: count reaches 2, iREN drops with imemaddr held at 0xC; inst_out unchanged; after release sequence continues 0x4,0x8,0xC with no gap duplication or loss.
- ihit delayed 3 cycles: iREN=1, imemaddr=0 stable all 3 cycles; inst_valid rises the cycle after ihit.
- Redirect to 0x100 while request 0x8 pending: flush_out=1 that cycle, inst_valid=0 next cycle, imemaddr stays 0x8 until ihit, that data dropped, next imemaddr=0x100, first valid pcp4_out=0x104.
- Redirect to 0x100 coincident with ihit for 0x8: word dropped, imemaddr=0x100 next cycle; redirect+halt together: HALT, flush_out=1.
- halt asserted: iREN=0 and inst_valid=0 next cycle onward, later redirect ignored; nRST pulse returns imemaddr=PC0 and fetching resumes.
